keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
- Scans a 4x4 active-low matrix keypad. Drives one column at a time, synchronises and debounces the row inputs, and emits a 4-bit key code with a one-cycle valid strobe.
- Sits directly upstream of the keypad encoder / register-bank write path.
- Also supplies an auto-incrementing 2-bit write address, so consecutive keypresses land in successive registers.

Parameters:
- SCAN_DIV, 1000: clock cycles each column stays driven; must be >= 4 to cover settling plus synchroniser latency.
- DEBOUNCE_CYCLES, 20000: consecutive stable cycles required to accept a press or a release; must be >= 2.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ena  in  1  block enable
- row_in  in  4  keypad rows, active-low, externally pulled up
- col_out  out  4  column strobes, one-hot active-low
- key_code  out  4  code of last accepted key = row*4 + col
- key_valid  out  1  one-cycle pulse when a press is accepted
- key_held  out  1  high while the accepted key remains pressed
- wr_addr  out  2  register-bank write address for the current key_valid

Behaviour:
- One clock. Reset is asynchronous and active-low; all flops clear on rst_n=0 regardless of clk.
- Reset values:
  - col_out=4'b1110 (column 0 driven)
  - key_code=0, key_valid=0, key_held=0, wr_addr=0
  - synchroniser flops=4'b1111, state=SCAN, all counters 0
- row_in passes through a 2-flop synchroniser; rows_s is the synchronised value. No logic uses raw row_in.
- Scan timer: counts 0..SCAN_DIV-1 in SCAN. The sample point is the cycle where the timer = SCAN_DIV-1.
- FSM states: SCAN, DEBOUNCE, HELD, RELEASE.
- SCAN:
  - At the sample point, if rows_s == 4'b1111: advance col_idx (3 wraps to 0) and clear the timer.
  - At the sample point, if any bit of rows_s is 0: latch col_idx, latch rows_s as the press pattern, clear the debounce counter, go to DEBOUNCE. The column does not advance.
- DEBOUNCE:
  - Column frozen.
  - Each cycle rows_s equals the latched pattern, increment the counter.
  - Any mismatch: go to SCAN, clear the timer, keep the same column.
  - When the counter reaches DEBOUNCE_CYCLES: on the next edge set key_code, pulse key_valid for exactly 1 cycle, and go to HELD.
  - Net result: key_valid rises DEBOUNCE_CYCLES+1 cycles after the detecting sample edge.
- Row priority: if several rows are low, the lowest-index low row sets the row in key_code. Pattern matching still uses the full 4-bit pattern.
- HELD:
  - key_held=1 in HELD and RELEASE; key_held=0 otherwise.
  - When rows_s == 4'b1111, clear the counter and go to RELEASE.
- RELEASE:
  - Each cycle rows_s == 4'b1111, increment the counter.
  - Any low row: return to HELD with no new key_valid. Bounces and ghost presses are swallowed.
  - When the counter reaches DEBOUNCE_CYCLES: go to SCAN, advance col_idx, clear the timer.
- wr_addr: holds the address for the current pulse during key_valid. Increments on the edge ending key_valid and wraps 3 to 0.
- key_code persists until the next accepted press.
- ena=0 (synchronous):
  - State forced to SCAN; timers and counters cleared; col_out=4'b1111; key_valid=0, key_held=0.
  - key_code, wr_addr and col_idx are held.
  - When ena returns to 1, scanning restarts from the held col_idx.
- Asynchronous reset mid-debounce or mid-hold: immediately returns every flop to its reset value, with no key_valid.
- Counter widths: $clog2(SCAN_DIV) for the scan timer; $clog2(DEBOUNCE_CYCLES+1) for the debounce counter. No overflow is possible because each counter stops at its terminal value.

Decomposition:
- Package keypad_pkg:
  - state enum: ST_SCAN, ST_DEBOUNCE, ST_HELD, ST_RELEASE
  - ROWS_IDLE = 4'b1111
  - row-priority encode function
  - key-code compose function: {row, col}
- One sub-module: sync_2ff, a 4-bit two-flop synchroniser with asynchronous active-low reset to all-ones.

Test Plan:
All scenarios use SCAN_DIV=4 and DEBOUNCE_CYCLES=8.
- Idle scan: rows all 1 for 32 cycles -> col_out cycles 1110, 1101, 1011, 0111 every 4 cycles and wraps; key_valid stays 0.
- Clean press: pull row 2 low only while column 1 is driven, then hold -> key_valid pulses once with key_code=4'd9 and wr_addr=0; key_held=1 until release is debounced; wr_addr then reads 1.
- Press bounce: toggle row 0 every 3 cycles during DEBOUNCE -> no key_valid; FSM returns to SCAN on the same column.
- Release bounce: in HELD, release row 2 for 5 cycles, re-press, then release cleanly -> exactly one key_valid in total; SCAN resumes after 8 stable idle cycles.
- Four presses -> wr_addr sequence 0, 1, 2, 3, then 0 on the fifth press; multi-row press of rows 1 and 3 on column 0 -> key_code=4'd4.
- Assert rst_n=0 mid-DEBOUNCE -> outputs at reset values in the same cycle, with no clock edge needed. Drop ena mid-HELD -> col_out=1111 and key_held=0 on the next edge.

Source files
------------

// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types and helpers for the keypad scanner
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_HELD,
    ST_RELEASE
  } state_t;

  localparam logic [3:0] ROWS_IDLE = 4'b1111;

  // Lowest-index low row wins when several rows read low.
  function automatic logic [1:0] row_encode(input logic [3:0] rows);
    logic [1:0] r;
    if (!rows[0]) begin
      r = 2'd0;
    end else if (!rows[1]) begin
      r = 2'd1;
    end else if (!rows[2]) begin
      r = 2'd2;
    end else begin
      r = 2'd3;
    end
    return r;
  endfunction

  // Key code is row*4 + col.
  function automatic logic [3:0] key_compose(input logic [1:0] row, input logic [1:0] col);
    return {row, col};
  endfunction

  // One-hot active-low column strobe for a column index.
  function automatic logic [3:0] col_decode(input logic [1:0] col);
    return ~(4'b0001 << col);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - 4-bit two-flop synchroniser, resets to idle (all ones)
module sync_2ff (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] i_d,
  output logic [3:0] o_q
);

  logic [3:0] r_meta;
  logic [3:0] r_sync;

  // Two back-to-back flops to resolve metastability on the raw rows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 4'b1111;
      r_sync <= 4'b1111;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 matrix keypad scanner with debounce and write address
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_CYCLES = 20000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held,
  output logic [1:0] wr_addr
);

  localparam int TW = $clog2(SCAN_DIV);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYCLES);

  logic [3:0]    w_rows_s;
  state_t        r_state;
  logic [TW-1:0] r_timer;
  logic [DW-1:0] r_cnt;
  logic [1:0]    r_col_idx;
  logic [3:0]    r_pattern;
  logic [3:0]    r_col_out;
  logic [3:0]    r_key_code;
  logic          r_key_valid;
  logic          r_key_held;
  logic [1:0]    r_wr_addr;

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (row_in),
    .o_q   (w_rows_s)
  );

  // Scan / debounce / hold / release sequencing with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_SCAN;
      r_timer     <= '0;
      r_cnt       <= '0;
      r_col_idx   <= 2'd0;
      r_pattern   <= ROWS_IDLE;
      r_col_out   <= 4'b1110;
      r_key_code  <= 4'd0;
      r_key_valid <= 1'b0;
      r_key_held  <= 1'b0;
      r_wr_addr   <= 2'd0;
    end else if (!ena) begin
      // Disabled: park in SCAN with columns released; code, address and column are kept.
      r_state     <= ST_SCAN;
      r_timer     <= '0;
      r_cnt       <= '0;
      r_col_out   <= 4'b1111;
      r_key_valid <= 1'b0;
      r_key_held  <= 1'b0;
    end else begin
      r_key_valid <= 1'b0;
      r_col_out   <= col_decode(r_col_idx);
      // Address moves on the edge that ends the strobe, so it is stable during it.
      if (r_key_valid) begin
        r_wr_addr <= r_wr_addr + 2'd1;
      end
      case (r_state)
        ST_SCAN: begin
          if (r_timer == TIMER_LAST) begin
            r_timer <= '0;
            if (w_rows_s == ROWS_IDLE) begin
              r_col_idx <= r_col_idx + 2'd1;
              r_col_out <= col_decode(r_col_idx + 2'd1);
            end else begin
              r_pattern <= w_rows_s;
              r_cnt     <= '0;
              r_state   <= ST_DEBOUNCE;
            end
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        ST_DEBOUNCE: begin
          if (w_rows_s != r_pattern) begin
            r_state <= ST_SCAN;
            r_timer <= '0;
          end else if (r_cnt == DEB_LAST) begin
            r_key_code  <= key_compose(row_encode(r_pattern), r_col_idx);
            r_key_valid <= 1'b1;
            r_key_held  <= 1'b1;
            r_state     <= ST_HELD;
          end else begin
            r_cnt <= r_cnt + DW'(1);
          end
        end
        ST_HELD: begin
          if (w_rows_s == ROWS_IDLE) begin
            r_cnt   <= '0;
            r_state <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (w_rows_s != ROWS_IDLE) begin
            // Bounce or ghost press while releasing: swallow it.
            r_state <= ST_HELD;
          end else if (r_cnt == DEB_LAST) begin
            r_state    <= ST_SCAN;
            r_key_held <= 1'b0;
            r_timer    <= '0;
            r_col_idx  <= r_col_idx + 2'd1;
            r_col_out  <= col_decode(r_col_idx + 2'd1);
          end else begin
            r_cnt <= r_cnt + DW'(1);
          end
        end
        default: begin
          r_state <= ST_SCAN;
        end
      endcase
    end
  end

  assign col_out   = r_col_out;
  assign key_code  = r_key_code;
  assign key_valid = r_key_valid;
  assign key_held  = r_key_held;
  assign wr_addr   = r_wr_addr;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - directed self-checking bench for keypad_scanner
module tb_keypad_scanner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;
  logic [1:0] wr_addr;

  logic [15:0] keys;
  int n_vec = 0;
  int n_err = 0;
  int k = 0;
  int pulses = 0;

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CYCLES(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .row_in    (row_in),
    .col_out   (col_out),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held),
    .wr_addr   (wr_addr)
  );

  always #5 clk = ~clk;

  // Matrix model: key (r,c) pulls row r low while column c is driven low.
  assign row_in[0] = ~|(keys[3:0]   & ~col_out);
  assign row_in[1] = ~|(keys[7:4]   & ~col_out);
  assign row_in[2] = ~|(keys[11:8]  & ~col_out);
  assign row_in[3] = ~|(keys[15:12] & ~col_out);

  always @(negedge clk) begin
    if (key_valid === 1'b1) pulses++;
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    k++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ena   = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    k = 0;
  endtask

  task automatic test_reset();
    keys  = 16'h0000;
    ena   = 1'b1;
    rst_n = 1'b0;
    #12;
    n_vec++; if (col_out !== 4'b1110) begin n_err++; $display("FAIL reset_col: got %b expected %b", col_out, 4'b1110); end
    n_vec++; if (key_code !== 4'd0) begin n_err++; $display("FAIL reset_code: got %0d expected 0", key_code); end
    n_vec++; if (key_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", key_valid); end
    n_vec++; if (key_held !== 1'b0) begin n_err++; $display("FAIL reset_held: got %b expected 0", key_held); end
    n_vec++; if (wr_addr !== 2'd0) begin n_err++; $display("FAIL reset_addr: got %0d expected 0", wr_addr); end
  endtask

  task automatic test_idle_scan();
    logic [3:0] exp_col;
    keys = 16'h0000;
    do_reset();
    repeat (32) begin
      step();
      exp_col = ~(4'b0001 << ((k / 4) % 4));
      n_vec++; if (col_out !== exp_col) begin n_err++; $display("FAIL idle_col k=%0d: got %b expected %b", k, col_out, exp_col); end
      n_vec++; if (key_valid !== 1'b0) begin n_err++; $display("FAIL idle_valid k=%0d: got %b expected 0", k, key_valid); end
    end
  endtask

  task automatic test_clean_press();
    int p0;
    keys = 16'h0200;
    do_reset();
    p0 = pulses;
    while (k < 45) begin
      step();
      if (k == 16) begin
        n_vec++; if (key_valid !== 1'b0) begin n_err++; $display("FAIL clean_early: got %b expected 0", key_valid); end
      end
      if (k == 17) begin
        n_vec++; if (key_valid !== 1'b1) begin n_err++; $display("FAIL clean_valid: got %b expected 1", key_valid); end
        n_vec++; if (key_code !== 4'd9) begin n_err++; $display("FAIL clean_code: got %0d expected 9", key_code); end
        n_vec++; if (wr_addr !== 2'd0) begin n_err++; $display("FAIL clean_addr: got %0d expected 0", wr_addr); end
        n_vec++; if (key_held !== 1'b1) begin n_err++; $display("FAIL clean_held: got %b expected 1", key_held); end
      end
      if (k == 18) begin
        n_vec++; if (key_valid !== 1'b0) begin n_err++; $display("FAIL clean_pulse_len: got %b expected 0", key_valid); end
        n_vec++; if (wr_addr !== 2'd1) begin n_err++; $display("FAIL clean_addr_inc: got %0d expected 1", wr_addr); end
      end
      if (k == 30) begin
        n_vec++; if (col_out !== 4'b1101) begin n_err++; $display("FAIL clean_col_frozen: got %b expected 1101", col_out); end
        keys = 16'h0000;
      end
      if (k == 41) begin
        n_vec++; if (key_held !== 1'b1) begin n_err++; $display("FAIL clean_held_late: got %b expected 1", key_held); end
      end
      if (k == 42) begin
        n_vec++; if (key_held !== 1'b0) begin n_err++; $display("FAIL clean_released: got %b expected 0", key_held); end
        n_vec++; if (col_out !== 4'b1011) begin n_err++; $display("FAIL clean_col_next: got %b expected 1011", col_out); end
        n_vec++; if (wr_addr !== 2'd1) begin n_err++; $display("FAIL clean_addr_after: got %0d expected 1", wr_addr); end
      end
    end
    n_vec++; if (pulses - p0 !== 1) begin n_err++; $display("FAIL clean_pulse_count: got %0d expected 1", pulses - p0); end
  endtask

  task automatic test_press_bounce();
    int p0;
    keys = 16'h0002;
    do_reset();
    p0 = pulses;
    while (k < 30) begin
      step();
      if (k >= 8 && k <= 29) begin
        n_vec++; if (col_out !== 4'b1101) begin n_err++; $display("FAIL bounce_col k=%0d: got %b expected 1101", k, col_out); end
      end
      if (k == 30) begin
        n_vec++; if (col_out !== 4'b1011) begin n_err++; $display("FAIL bounce_resume: got %b expected 1011", col_out); end
      end
      if (k == 11 || k == 14 || k == 17 || k == 20 || k == 23) keys[1] = ~keys[1];
    end
    n_vec++; if (pulses - p0 !== 0) begin n_err++; $display("FAIL bounce_pulses: got %0d expected 0", pulses - p0); end
  endtask

  task automatic test_release_bounce();
    int p0;
    keys = 16'h0200;
    do_reset();
    p0 = pulses;
    while (k < 50) begin
      step();
      if (k == 17) begin
        n_vec++; if (key_valid !== 1'b1) begin n_err++; $display("FAIL relb_valid: got %b expected 1", key_valid); end
      end
      if (k == 22) keys = 16'h0000;
      if (k == 27) keys = 16'h0200;
      if (k == 29 || k == 33 || k == 46) begin
        n_vec++; if (key_held !== 1'b1) begin n_err++; $display("FAIL relb_held k=%0d: got %b expected 1", k, key_held); end
      end
      if (k == 33) begin
        n_vec++; if (col_out !== 4'b1101) begin n_err++; $display("FAIL relb_col: got %b expected 1101", col_out); end
      end
      if (k == 35) keys = 16'h0000;
      if (k == 47) begin
        n_vec++; if (key_held !== 1'b0) begin n_err++; $display("FAIL relb_release: got %b expected 0", key_held); end
        n_vec++; if (col_out !== 4'b1011) begin n_err++; $display("FAIL relb_scan: got %b expected 1011", col_out); end
      end
    end
    n_vec++; if (pulses - p0 !== 1) begin n_err++; $display("FAIL relb_pulses: got %0d expected 1", pulses - p0); end
  endtask

  task automatic test_wr_addr_seq();
    logic [15:0] masks [5] = '{16'h0200, 16'h0040, 16'h8000, 16'h0008, 16'h1010};
    logic [3:0]  codes [5] = '{4'd9, 4'd6, 4'd15, 4'd3, 4'd4};
    int budget;
    keys = 16'h0000;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      keys = masks[i];
      budget = 0;
      while (key_valid !== 1'b1 && budget < 100) begin step(); budget++; end
      n_vec++; if (key_valid !== 1'b1) begin n_err++; $display("FAIL seq_timeout press %0d: got %b expected 1", i, key_valid); end
      n_vec++; if (wr_addr !== 2'(i % 4)) begin n_err++; $display("FAIL seq_addr press %0d: got %0d expected %0d", i, wr_addr, i % 4); end
      n_vec++; if (key_code !== codes[i]) begin n_err++; $display("FAIL seq_code press %0d: got %0d expected %0d", i, key_code, codes[i]); end
      keys = 16'h0000;
      budget = 0;
      while (key_held !== 1'b0 && budget < 100) begin step(); budget++; end
      n_vec++; if (key_held !== 1'b0) begin n_err++; $display("FAIL seq_release press %0d: got %b expected 0", i, key_held); end
    end
  endtask

  task automatic test_async_reset();
    int p0;
    int budget;
    n_vec++; if (wr_addr !== 2'd1) begin n_err++; $display("FAIL ares_pre_addr: got %0d expected 1", wr_addr); end
    n_vec++; if (key_code !== 4'd4) begin n_err++; $display("FAIL ares_pre_code: got %0d expected 4", key_code); end
    budget = 0;
    while (col_out !== 4'b1110 && budget < 40) begin step(); budget++; end
    n_vec++; if (col_out !== 4'b1110) begin n_err++; $display("FAIL ares_find_col0: got %b expected 1110", col_out); end
    keys = 16'h0001;
    p0 = pulses;
    repeat (4) step();
    n_vec++; if (col_out !== 4'b1110) begin n_err++; $display("FAIL ares_detect_col: got %b expected 1110", col_out); end
    repeat (4) step();
    n_vec++; if (key_held !== 1'b0) begin n_err++; $display("FAIL ares_mid_deb: got %b expected 0", key_held); end
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++; if (col_out !== 4'b1110) begin n_err++; $display("FAIL ares_col: got %b expected 1110", col_out); end
    n_vec++; if (key_code !== 4'd0) begin n_err++; $display("FAIL ares_code: got %0d expected 0", key_code); end
    n_vec++; if (wr_addr !== 2'd0) begin n_err++; $display("FAIL ares_addr: got %0d expected 0", wr_addr); end
    n_vec++; if (key_valid !== 1'b0) begin n_err++; $display("FAIL ares_valid: got %b expected 0", key_valid); end
    n_vec++; if (key_held !== 1'b0) begin n_err++; $display("FAIL ares_held: got %b expected 0", key_held); end
    keys = 16'h0000;
    @(negedge clk);
    rst_n = 1'b1;
    k = 0;
    repeat (20) step();
    n_vec++; if (pulses - p0 !== 0) begin n_err++; $display("FAIL ares_no_pulse: got %0d expected 0", pulses - p0); end
    n_vec++; if (col_out !== 4'b1101) begin n_err++; $display("FAIL ares_rescan: got %b expected 1101", col_out); end
  endtask

  task automatic test_ena_drop();
    keys = 16'h0200;
    do_reset();
    while (k < 36) begin
      step();
      if (k == 20) begin
        n_vec++; if (key_held !== 1'b1) begin n_err++; $display("FAIL ena_pre_held: got %b expected 1", key_held); end
        ena = 1'b0;
      end
      if (k == 21) begin
        n_vec++; if (col_out !== 4'b1111) begin n_err++; $display("FAIL ena_col_off: got %b expected 1111", col_out); end
        n_vec++; if (key_held !== 1'b0) begin n_err++; $display("FAIL ena_held_off: got %b expected 0", key_held); end
        n_vec++; if (key_code !== 4'd9) begin n_err++; $display("FAIL ena_code_kept: got %0d expected 9", key_code); end
        n_vec++; if (wr_addr !== 2'd1) begin n_err++; $display("FAIL ena_addr_kept: got %0d expected 1", wr_addr); end
        ena = 1'b1;
      end
      if (k == 22) begin
        n_vec++; if (col_out !== 4'b1101) begin n_err++; $display("FAIL ena_col_resume: got %b expected 1101", col_out); end
      end
      if (k == 33) begin
        n_vec++; if (key_valid !== 1'b0) begin n_err++; $display("FAIL ena_early: got %b expected 0", key_valid); end
      end
      if (k == 34) begin
        n_vec++; if (key_valid !== 1'b1) begin n_err++; $display("FAIL ena_repress: got %b expected 1", key_valid); end
        n_vec++; if (wr_addr !== 2'd1) begin n_err++; $display("FAIL ena_repress_addr: got %0d expected 1", wr_addr); end
      end
    end
    keys = 16'h0000;
  endtask

  initial begin
    keys  = 16'h0000;
    rst_n = 1'b0;
    ena   = 1'b1;
    test_reset();
    test_idle_scan();
    test_clean_press();
    test_press_bounce();
    test_release_bounce();
    test_wr_addr_seq();
    test_async_reset();
    test_ena_drop();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
